// File: rtl/ahb_slave_responder.sv
// AHB slave responder: one 32-bit storage word per address in [LOW_ADDR, HIGH_ADDR],
// programmable wait states, two-cycle ERROR response for out-of-window or oversize accesses.
module ahb_slave_responder #(
    parameter logic [31:0] LOW_ADDR    = 32'd0,
    parameter logic [31:0] HIGH_ADDR   = 32'd31,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    localparam int         DEPTH      = int'(HIGH_ADDR - LOW_ADDR) + 1;
    localparam int         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_LAST  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OKAY_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic [31:0]      mem_q [DEPTH];

    logic [31:0] offset;
    logic        accept;
    logic        addr_err;
    logic        mem_we;
    logic        ready_out;
    logic [1:0]  resp_out;

    assign offset   = HADDR - LOW_ADDR;
    assign accept   = HSEL && HREADY && HTRANS[1];
    assign addr_err = (HADDR < LOW_ADDR) || (HADDR > HIGH_ADDR) || (HSIZE > SIZE_WORD);
    assign mem_we   = (state_q == ST_OKAY_DONE) && write_q;

    assign HREADYOUT = ready_out;
    assign HRESP     = resp_out;
    assign HRDATA    = ((state_q == ST_OKAY_DONE) && !write_q) ? mem_q[idx_q] : 32'd0;

    // Burst type and the BUSY/IDLE distinction do not change the response.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0], offset[31:IDX_W]};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        ready_out  = 1'b1;
        resp_out   = RESP_OKAY;

        unique case (state_q)
            ST_WAIT: begin
                ready_out = 1'b0;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_OKAY_DONE;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_ERR1: begin
                ready_out = 1'b0;
                resp_out  = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: resp_out = RESP_ERROR;
            default: ;
        endcase

        // IDLE, OKAY_DONE and ERR2 all end a data phase, so each may take the next address phase.
        if (ready_out) begin
            if (accept) begin
                idx_d      = offset[IDX_W-1:0];
                write_d    = HWRITE;
                wait_cnt_d = 3'd0;
                if (addr_err)             state_d = ST_ERR1;
                else if (WAIT_STATES > 0) state_d = ST_WAIT;
                else                      state_d = ST_OKAY_DONE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            // NOTE: storage is part of the reset state, so every word is cleared synchronously here.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            if (mem_we) mem_q[idx_q] <= HWDATA;
        end
    end
endmodule

// File: tb/tb_ahb_slave_responder.sv
// Self-checking bench: two responders (0 and 1 wait states) on one shared master,
// each compared every cycle against a transaction-level response-schedule model.
module tb_ahb_slave_responder;
    localparam logic [31:0] LO    = 32'd32;
    localparam logic [31:0] HI    = 32'd62;
    localparam int          WORDS = 31;
    localparam logic [1:0]  OKAY = 2'd0, ERROR = 2'd1;
    localparam logic [1:0]  T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset, hsel, hwrite, bus_rdy;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    wire  [1:0]  hro;
    wire  [1:0]  hready_w;
    wire  [3:0]  hrsp;
    wire  [63:0] hrd;

    assign hready_w = hro & {2{bus_rdy}};

    ahb_slave_responder #(.LOW_ADDR(LO), .HIGH_ADDR(HI), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready_w[0]), .HREADYOUT(hro[0]), .HRESP(hrsp[1:0]), .HRDATA(hrd[31:0])
    );

    ahb_slave_responder #(.LOW_ADDR(LO), .HIGH_ADDR(HI), .WAIT_STATES(1)) u_dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready_w[1]), .HREADYOUT(hro[1]), .HRESP(hrsp[3:2]), .HRDATA(hrd[63:32])
    );

    // One expected bus cycle of a transfer; fin marks the OKAY completion cycle.
    typedef struct packed {
        logic       rdy;
        logic [1:0] resp;
        logic       fin;
        logic       wr;
        logic [4:0] idx;
    } beat_t;

    beat_t       sch   [2][8];
    int          sch_n [2];
    logic [31:0] mem_m [2][WORDS];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t front(input int d);
        beat_t r;
        r = '{rdy: 1'b1, resp: OKAY, fin: 1'b0, wr: 1'b0, idx: 5'd0};
        if (sch_n[d] > 0) r = sch[d][0];
        return r;
    endfunction

    task automatic push(input int d, input beat_t b);
        sch[d][sch_n[d]] = b;
        sch_n[d]++;
    endtask

    // Applies the bus rules for one rising edge, using the inputs present before it.
    task automatic model_edge(input int d);
        beat_t cur;
        int    ws;
        ws  = (d == 0) ? 0 : 1;
        cur = front(d);
        if (hreset) begin
            sch_n[d] = 0;
            for (int i = 0; i < WORDS; i++) mem_m[d][i] = 32'd0;
        end else begin
            if (cur.fin && cur.wr) mem_m[d][cur.idx] = hwdata;
            if (sch_n[d] > 0) begin
                for (int i = 0; i < 7; i++) sch[d][i] = sch[d][i+1];
                sch_n[d]--;
            end
            if (cur.rdy && hsel && bus_rdy && htrans[1]) begin
                if (haddr < LO || haddr > HI || hsize > 3'd2) begin
                    push(d, '{rdy: 1'b0, resp: ERROR, fin: 1'b0, wr: 1'b0, idx: 5'd0});
                    push(d, '{rdy: 1'b1, resp: ERROR, fin: 1'b0, wr: 1'b0, idx: 5'd0});
                end else begin
                    for (int i = 0; i < ws; i++)
                        push(d, '{rdy: 1'b0, resp: OKAY, fin: 1'b0, wr: 1'b0, idx: 5'd0});
                    push(d, '{rdy: 1'b1, resp: OKAY, fin: 1'b1, wr: hwrite, idx: 5'(haddr - LO)});
                end
            end
        end
    endtask

    task automatic step();
        beat_t b;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            b = front(d);
            check($sformatf("model_hreadyout%0d", d), 32'(hro[d]), 32'(b.rdy));
            check($sformatf("model_hresp%0d", d), 32'(hrsp[d*2 +: 2]), 32'(b.resp));
            check($sformatf("model_hrdata%0d", d), hrd[d*32 +: 32],
                  (b.fin && !b.wr) ? mem_m[d][b.idx] : 32'd0);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        hwdata = wdata;
    endtask

    task automatic expect_out(input int d, input string tag, input logic rdy,
                              input logic [1:0] resp, input logic [31:0] rdata);
        check({tag, "_rdy"}, 32'(hro[d]), 32'(rdy));
        check({tag, "_resp"}, 32'(hrsp[d*2 +: 2]), 32'(resp));
        check({tag, "_rdata"}, hrd[d*32 +: 32], rdata);
    endtask

    // Single transfer seen by the one-wait-state responder: stall cycle, completion, idle.
    task automatic xfer1(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata);
        drive(1'b1, T_NONSEQ, wr, addr, size, wdata);
        step();
        expect_out(1, {tag, "_p1"}, 1'b0, err ? ERROR : OKAY, 32'd0);
        drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'd2, wdata);
        step();
        expect_out(1, {tag, "_p2"}, 1'b1, err ? ERROR : OKAY, rdata);
        step();
        expect_out(1, {tag, "_idle"}, 1'b1, OKAY, 32'd0);
    endtask

    logic [31:0] bd [4];

    initial begin
        sch_n[0] = 0;
        sch_n[1] = 0;
        bus_rdy  = 1'b1;
        hburst   = 3'd0;
        hreset   = 1'b1;
        drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'd2, 32'd0);
        step();
        step();
        expect_out(1, "reset1", 1'b1, OKAY, 32'd0);
        expect_out(0, "reset0", 1'b1, OKAY, 32'd0);

        // Write issued in the very first cycle after reset release, then read back.
        hreset = 1'b0;
        xfer1("wr40", 1'b1, 32'd40, 3'd2, 32'hA5A5_0001, 1'b0, 32'd0);
        xfer1("rd40", 1'b0, 32'd40, 3'd2, 32'd0, 1'b0, 32'hA5A5_0001);
        xfer1("rd63", 1'b0, 32'd63, 3'd2, 32'd0, 1'b1, 32'd0);
        xfer1("wr33x2", 1'b1, 32'd33, 3'd3, 32'hFFFF_FFFF, 1'b1, 32'd0);
        xfer1("rd33", 1'b0, 32'd33, 3'd2, 32'd0, 1'b0, 32'd0);

        // BUSY and deselected transfers must leave the stored word alone.
        xfer1("wr34", 1'b1, 32'd34, 3'd2, 32'h0000_3434, 1'b0, 32'd0);
        drive(1'b1, T_BUSY, 1'b1, 32'd34, 3'd2, 32'hDEAD_BEEF);
        step();
        expect_out(1, "busy", 1'b1, OKAY, 32'd0);
        drive(1'b0, T_NONSEQ, 1'b1, 32'd34, 3'd2, 32'hDEAD_BEEF);
        step();
        expect_out(1, "nosel", 1'b1, OKAY, 32'd0);
        xfer1("rd34", 1'b0, 32'd34, 3'd2, 32'd0, 1'b0, 32'h0000_3434);

        // Reset during the wait cycle of a write.
        drive(1'b1, T_NONSEQ, 1'b1, 32'd45, 3'd2, 32'h1234_5678);
        step();
        expect_out(1, "wr45_wait", 1'b0, OKAY, 32'd0);
        hreset = 1'b1;
        drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'd2, 32'h1234_5678);
        step();
        expect_out(1, "wr45_rst", 1'b1, OKAY, 32'd0);
        hreset = 1'b0;
        xfer1("rd45", 1'b0, 32'd45, 3'd2, 32'd0, 1'b0, 32'd0);

        // INCR4 write then read burst, fully pipelined on the zero-wait responder.
        for (int k = 0; k < 4; k++) bd[k] = $urandom;
        hburst = 3'd3;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k == 0) ? T_NONSEQ : T_SEQ, 1'b1, 32'(50 + k), 3'd2,
                  (k == 0) ? 32'd0 : bd[k-1]);
            step();
            expect_out(0, $sformatf("bwr%0d", k), 1'b1, OKAY, 32'd0);
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, (j == 0) ? T_NONSEQ : T_SEQ, 1'b0, 32'(50 + j), 3'd2,
                  (j == 0) ? bd[3] : 32'd0);
            step();
            expect_out(0, $sformatf("brd%0d", j), 1'b1, OKAY, bd[j]);
        end
        hburst = 3'd0;
        drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'd2, 32'd0);
        step();
        expect_out(0, "burst_end", 1'b1, OKAY, 32'd0);
        step();

        // Random traffic, including stalls from elsewhere on the bus and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            hreset  = ($urandom_range(0, 99) == 0);
            bus_rdy = ($urandom_range(0, 9) != 0);
            hsel    = ($urandom_range(0, 3) != 0);
            htrans  = 2'($urandom_range(0, 3));
            hwrite  = 1'($urandom_range(0, 1));
            haddr   = 32'($urandom_range(28, 66));
            hsize   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            hburst  = 3'($urandom_range(0, 7));
            hwdata  = $urandom;
            step();
        end

        hreset  = 1'b0;
        bus_rdy = 1'b1;
        drive(1'b0, T_IDLE, 1'b0, 32'd0, 3'd2, 32'd0);
        step();
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahb_slave_responder.md
AHB_SLAVE_RESPONDER -- requirements
Module: ahb_slave_responder

Interface
REQ-001 The block SHALL have parameter LOW_ADDR, default 32'd0, meaning the lowest address decoded by this slave (inclusive).
REQ-002 The block SHALL have parameter HIGH_ADDR, default 32'd31, meaning the highest address decoded by this slave (inclusive).
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning HREADYOUT-low cycles inserted before each OKAY completion.
REQ-004 The block SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port HSEL, input, 1 bit: slave select from the decoder.
REQ-007 The block SHALL have port HADDR, input, 32 bits: address-phase address.
REQ-008 The block SHALL have port HTRANS, input, 2 bits: transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 The block SHALL have port HWRITE, input, 1 bit: 1=WRITE, 0=READ.
REQ-010 The block SHALL have port HSIZE, input, 3 bits: transfer size (BYTE=0 .. WORDx32=7).
REQ-011 The block SHALL have port HBURST, input, 3 bits: burst type (SINGLE..INCR16); accepted, no functional effect.
REQ-012 The block SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-013 The block SHALL have port HREADY, input, 1 bit: bus-level ready; address phases are sampled only when 1.
REQ-014 The block SHALL have port HREADYOUT, output, 1 bit: this slave's transfer-done indication.
REQ-015 The block SHALL have port HRESP, output, 2 bits: response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3); RETRY/SPLIT never driven.
REQ-016 The block SHALL have port HRDATA, output, 32 bits: read data.

Function
REQ-017 The block SHALL hold storage of (HIGH_ADDR-LOW_ADDR+1) 32-bit words, indexed by HADDR-LOW_ADDR (one word per address).
REQ-018 The block SHALL accept an address phase when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ, registering HADDR, HWRITE and HSIZE.
REQ-019 The block SHALL treat an accepted transfer as erroneous when HADDR<LOW_ADDR, HADDR>HIGH_ADDR or HSIZE>WORD.
REQ-020 The block SHALL answer IDLE/BUSY transfers, or HSEL=0, with zero-wait OKAY: HREADYOUT=1, HRESP=OKAY.
REQ-021 The block SHALL implement the states IDLE, WAIT, OKAY_DONE, ERR1 and ERR2.
REQ-022 The block SHALL transition from IDLE on an accepted transfer to ERR1 (if erroneous), else to WAIT (WAIT_STATES>0), else to OKAY_DONE.
REQ-023 In WAIT the block SHALL drive HREADYOUT=0 with HRESP=OKAY for exactly WAIT_STATES cycles, then enter OKAY_DONE.
REQ-024 In OKAY_DONE the block SHALL drive HREADYOUT=1 and HRESP=OKAY; a read drives HRDATA=mem[index] in that cycle; a write stores HWDATA into mem[index] at that cycle's clock edge.
REQ-025 In ERR1 the block SHALL drive HREADYOUT=0, HRESP=ERROR; in ERR2, HREADYOUT=1, HRESP=ERROR; storage is never modified by an erroneous transfer.
REQ-026 In OKAY_DONE or ERR2 the block SHALL sample a new address phase as in REQ-018 (back-to-back pipelining): accepted -> state per REQ-022; else -> IDLE.
REQ-027 The block SHALL ignore address-phase inputs while HREADYOUT=0.
REQ-028 The block SHALL give a read of an address written in the immediately preceding transfer the newly written data.
REQ-029 The block SHALL drive HRDATA=0 in every cycle other than a read in OKAY_DONE.

Reset
REQ-030 The block SHALL, on HCLK rising edge with HRESET=1, enter IDLE, drive HREADYOUT=1, HRESP=OKAY, HRDATA=0, clear the wait counter, and clear all storage words to 0.
REQ-031 The block SHALL abandon any in-progress transfer (WAIT, ERR1, OKAY_DONE) when HRESET asserts mid-transfer, with no storage update.
REQ-032 The block SHALL accept a new address phase in the first cycle after HRESET deasserts.

Verification
REQ-033 LOW=32, HIGH=62, WAIT=1: NONSEQ write 32'hA5A5_0001 to 40, then NONSEQ read of 40 -> each transfer: one HREADYOUT=0 cycle, then HREADYOUT=1/OKAY; read returns 32'hA5A5_0001.
REQ-034 Read of address 63 (out of window) -> HREADYOUT=0/ERROR, then HREADYOUT=1/ERROR; HRDATA=0; mem unchanged.
REQ-035 Write to 33 with HSIZE=WORDx2 -> two-cycle ERROR response; subsequent read of 33 returns 0.
REQ-036 WAIT=0: INCR4 burst NONSEQ+3 SEQ writes to 50..53, then INCR4 reads -> every cycle HREADYOUT=1/OKAY; reads return the written data in order.
REQ-037 HRESET asserted during WAIT of a write to 45 -> next cycle HREADYOUT=1/OKAY, state IDLE; read of 45 returns 0.
REQ-038 HTRANS=BUSY, or HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=OKAY, no storage change.
